// File: rtl/vm_order_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vm_order_sequencer
// Description : Coin/selection front end that holds the dispense decoder's
//               request lines until Ack, then pays change or refunds.
// Revision    : 1.0
// ============================================================================
module vm_order_sequencer #(
  parameter int PRICE   = 3,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 200,
  parameter int TO_W    = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             CoinIn,
  input  logic             SelMojo,
  input  logic             SelFizzUp,
  input  logic             Cancel,
  input  logic             Ack,
  output logic             Mojo,
  output logic             Taka,
  output logic             FizzUp,
  output logic [CNT_W-1:0] Credit,
  output logic             Refund,
  output logic             Reject,
  output logic             Busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_ORDER   = 2'd2,
    S_REFUND  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_PRICE   = CNT_W'(PRICE);
  localparam logic [CNT_W-1:0] C_MAX     = {CNT_W{1'b1}};
  localparam logic [TO_W-1:0]  C_TIMEOUT = TO_W'(TIMEOUT);

  state_t           r_state;
  logic             r_sel_mojo;
  logic             r_sel_fizz;
  logic [TO_W-1:0]  r_to;

  logic             w_sel_mojo;
  logic             w_sel_fizz;
  logic             w_activity;
  logic             w_can_order;
  logic [TO_W-1:0]  w_to_inc;
  logic [CNT_W-1:0] w_change;

  // A single button pulse replaces any earlier choice; both together set both.
  always_comb begin
    w_sel_mojo = r_sel_mojo;
    w_sel_fizz = r_sel_fizz;
    if (SelMojo && SelFizzUp) begin
      w_sel_mojo = 1'b1;
      w_sel_fizz = 1'b1;
    end else if (SelMojo) begin
      w_sel_mojo = 1'b1;
      w_sel_fizz = 1'b0;
    end else if (SelFizzUp) begin
      w_sel_mojo = 1'b0;
      w_sel_fizz = 1'b1;
    end
  end

  assign w_activity  = CoinIn | SelMojo | SelFizzUp;
  assign w_can_order = (Credit >= C_PRICE) && (r_sel_mojo || r_sel_fizz);
  assign w_to_inc    = r_to + 1'b1;
  assign w_change    = Credit - C_PRICE;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= S_IDLE;
      Credit     <= '0;
      r_sel_mojo <= 1'b0;
      r_sel_fizz <= 1'b0;
      r_to       <= '0;
      Mojo       <= 1'b0;
      Taka       <= 1'b0;
      FizzUp     <= 1'b0;
      Refund     <= 1'b0;
      Reject     <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      Refund <= 1'b0;
      Reject <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sel_mojo <= w_sel_mojo;
          r_sel_fizz <= w_sel_fizz;
          if (CoinIn) begin
            Credit  <= CNT_W'(1);
            r_to    <= '0;
            r_state <= S_COLLECT;
          end
        end

        S_COLLECT: begin
          if (Cancel) begin
            Reject     <= CoinIn;
            r_sel_mojo <= 1'b0;
            r_sel_fizz <= 1'b0;
            r_to       <= '0;
            r_state    <= S_REFUND;
            Busy       <= 1'b1;
          end else if (w_can_order) begin
            // Order commits on registered credit/latches; inputs this cycle are not taken.
            Reject  <= CoinIn;
            Mojo    <= r_sel_mojo;
            FizzUp  <= r_sel_fizz;
            Taka    <= 1'b1;
            r_to    <= '0;
            r_state <= S_ORDER;
            Busy    <= 1'b1;
          end else begin
            if (CoinIn) begin
              if (Credit == C_MAX) begin
                Reject <= 1'b1;
              end else begin
                Credit <= Credit + 1'b1;
              end
            end
            r_sel_mojo <= w_sel_mojo;
            r_sel_fizz <= w_sel_fizz;
            if (w_activity) begin
              r_to <= '0;
            end else if (w_to_inc == C_TIMEOUT) begin
              r_to       <= '0;
              r_sel_mojo <= 1'b0;
              r_sel_fizz <= 1'b0;
              r_state    <= S_REFUND;
              Busy       <= 1'b1;
            end else begin
              r_to <= w_to_inc;
            end
          end
        end

        S_ORDER: begin
          Reject <= CoinIn;
          if (Ack) begin
            Mojo       <= 1'b0;
            Taka       <= 1'b0;
            FizzUp     <= 1'b0;
            r_sel_mojo <= 1'b0;
            r_sel_fizz <= 1'b0;
            if (r_sel_mojo && r_sel_fizz) begin
              r_state <= S_REFUND;
            end else begin
              Credit <= w_change;
              if (w_change != '0) begin
                r_state <= S_REFUND;
              end else begin
                r_state <= S_IDLE;
                Busy    <= 1'b0;
              end
            end
          end
        end

        S_REFUND: begin
          Reject <= CoinIn;
          if (Credit != '0) begin
            Refund <= 1'b1;
            Credit <= Credit - 1'b1;
          end else begin
            r_state <= S_IDLE;
            Busy    <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/vm_order_sequencer.md
# vm_order_sequencer

Clocked front end of the vending machine that sits directly upstream of the combinational dispense decoder. It counts inserted coins, latches the drink selection, and once credit covers the price it holds the decoder's `Mojo`/`Taka`/`FizzUp` request lines steady until the dispenser acknowledges. It then returns change, or refunds everything on cancel, timeout or an illegal double selection, one coin pulse per cycle.

## Interface
- `PRICE`, default 3: coins required per drink; must be between 1 and 2^`CNT_W`-1.
- `CNT_W`, default 4: width of the credit counter.
- `TIMEOUT`, default 200: idle cycles allowed in COLLECT before an automatic refund; must be at least 1.
- `TO_W`, default 8: width of the timeout counter; must hold `TIMEOUT`.
- `Clk`  in  1  single system clock; rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `CoinIn`  in  1  one-cycle pulse, one coin inserted.
- `SelMojo`  in  1  one-cycle pulse, Mojo button.
- `SelFizzUp`  in  1  one-cycle pulse, FizzUp button.
- `Cancel`  in  1  one-cycle pulse, customer cancel.
- `Ack`  in  1  dispenser done; sampled only in ORDER.
- `Mojo`  out  1  request line to the decoder.
- `Taka`  out  1  "paid" line to the decoder.
- `FizzUp`  out  1  request line to the decoder.
- `Credit`  out  `CNT_W`  current credit, registered.
- `Refund`  out  1  one-cycle pulse per coin returned.
- `Reject`  out  1  one-cycle pulse; the coin was not accepted.
- `Busy`  out  1  high in ORDER and REFUND.

## Operation
- **States:** IDLE, COLLECT, ORDER, REFUND. Encoding is free.
- **Reset:** synchronous; takes effect at the next edge whatever the state, including mid-ORDER and mid-REFUND.
  - After reset: state IDLE, `Credit`=0, selection latches cleared, timeout counter 0.
  - All outputs 0. No refund is issued for credit lost to reset.
- **IDLE:**
  - `CoinIn` → `Credit`=1, go to COLLECT.
  - A selection pulse is latched and the state stays IDLE.
- **COLLECT, coins and selection:**
  - `CoinIn` adds 1 to `Credit`. At `Credit`=2^`CNT_W`-1 the coin is not counted and `Reject` pulses.
  - A selection pulse sets its latch. A later pulse of the other button replaces it.
  - `SelMojo` and `SelFizzUp` asserted in the same cycle set both latches.
- **COLLECT, timeout:**
  - The timeout counter resets on any `CoinIn`, `SelMojo` or `SelFizzUp`, and increments otherwise.
  - Reaching `TIMEOUT` → go to REFUND.
- **COLLECT, cancel:** `Cancel` → go to REFUND. Cancel wins over a coin or selection in the same cycle; that coin is rejected.
- **COLLECT → ORDER:** when the registered `Credit` ≥ `PRICE` and at least one latch is set at a clock edge, the next state is ORDER.
- **ORDER:**
  - Outputs are registered: `Taka`=1, `Mojo`=Mojo latch, `FizzUp`=FizzUp latch, held constant until `Ack`.
  - Both latches set drives all three lines high, which exercises the decoder's Error path.
  - `CoinIn` pulses `Reject`. Selection pulses and `Cancel` are ignored.
- **On `Ack` in ORDER:**
  - The three request lines drop at the same edge; latches are cleared.
  - Double selection: `Credit` is unchanged and the machine goes to REFUND (full refund).
  - Otherwise `Credit` ← `Credit`-`PRICE`, then REFUND if the result is nonzero, else IDLE.
- **REFUND:**
  - Each cycle `Refund`=1 and `Credit` decrements by 1; the state returns to IDLE in the cycle `Credit` reaches 0.
  - `CoinIn` pulses `Reject`. All other inputs are ignored.
- **Arithmetic:** unsigned and `CNT_W` wide. Subtraction only happens when `Credit` ≥ `PRICE`, so it never underflows.

## Timing
- Every output is registered; there is no combinational path from input to output.
- Coin accounting: a pulse at edge N updates `Credit` after edge N.
- Entry to ORDER: if the final coin and the pending selection are sampled at edge N, ORDER and the request lines are valid after edge N+1.
- Leaving ORDER: `Ack` sampled at edge M → lines low and the new `Credit` after edge M.
- Change: k coins of change produce k consecutive `Refund` cycles starting after edge M+1. Back in IDLE after edge M+k+1.
- `Reject` and `Refund` are exactly one cycle per event.
- `Busy` is registered and high whenever the state is ORDER or REFUND.

## Test plan
- **Exact price.** Reset, then 3 `CoinIn`, then `SelMojo`:
  - ORDER with `Mojo`=1, `Taka`=1, `FizzUp`=0.
  - `Ack` → `Credit`=0, IDLE, no `Refund`.
- **Change.** 5 coins, `SelFizzUp`, `Ack`:
  - `FizzUp`=1 and `Taka`=1 while in ORDER.
  - Then exactly 2 `Refund` pulses; `Credit` goes 2→1→0.
- **Double selection.** 3 coins, then `SelMojo` and `SelFizzUp` in the same cycle:
  - All three request lines high.
  - `Ack` → 3 `Refund` pulses, no price deducted.
- **Cancel and timeout.**
  - 2 coins then `Cancel` → 2 `Refund` pulses.
  - Separately, 1 coin then `TIMEOUT` quiet cycles → 1 `Refund` pulse.
- **Saturation and busy.**
  - 16 coins with `CNT_W`=4 → `Credit`=15 and one `Reject`.
  - A coin during ORDER → `Reject` with `Credit` unchanged.
- **Reset mid-operation.** Assert `Rst` in ORDER and again in REFUND:
  - Next cycle all outputs 0, `Credit`=0, IDLE.
  - No further `Refund` pulses.
